// File: rtl/carry_pipe_pkg.sv
// rtl/carry_pipe_pkg.sv - shared constants, stage-count helper and stage record for the sliced carry-chain adder
package carry_pipe_pkg;

  localparam int SLICE_DEF = 4;
  localparam int WIDTH_DEF = 16;

  function automatic int stages_of(input int width, input int slice);
    return width / slice;
  endfunction

  // Contents of one pipeline stage at the default geometry.
  typedef struct packed {
    logic                 valid;
    logic [WIDTH_DEF-1:0] partial_sum;
    logic                 carry;
    logic [WIDTH_DEF-1:0] a_rem;
    logic [WIDTH_DEF-1:0] b_rem;
  } stage_rec_t;

endpackage

// File: rtl/carry_chain_segment.sv
// rtl/carry_chain_segment.sv - one SLICE-bit fabric carry chain: a carry-init cell followed by plain propagate cells
module carry_chain_segment
  import carry_pipe_pkg::*;
#(
  parameter int SLICE = SLICE_DEF
) (
  input  logic [SLICE-1:0] a_seg,
  input  logic [SLICE-1:0] b_seg,
  input  logic             cin,
  output logic [SLICE-1:0] s_seg,
  output logic             cout,
  output logic             c_msb_in
);

  logic [SLICE:0]   c;
  logic [SLICE-1:0] p;

  // c[0] is the carry-init input of the first cell; the mux DI leg is the A bit.
  assign c[0] = cin;
  assign p    = a_seg ^ b_seg;

  for (genvar i = 0; i < SLICE; i++) begin : g_cell
    assign c[i+1] = p[i] ? c[i] : a_seg[i];
  end

  assign s_seg    = p ^ c[SLICE-1:0];
  assign cout     = c[SLICE];
  assign c_msb_in = c[SLICE-1];

endmodule

// File: rtl/carry_chain_pipe_adder.sv
// rtl/carry_chain_pipe_adder.sv - slice-pipelined WIDTH-bit add/sub, one carry segment per stage, full-stall valid/ready
module carry_chain_pipe_adder
  import carry_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ov
);

  localparam int STAGES = stages_of(WIDTH, SLICE);

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign cin0     = sub | ci;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int RW = WIDTH - k * SLICE;   // operand bits still to be added on entry
    localparam int PW = (k + 1) * SLICE;     // result bits known after this stage

    logic [RW-1:0]    a_in;
    logic [RW-1:0]    b_in;
    logic             cin_k;
    logic             v_in;
    logic [PW-1:0]    ps_d;
    logic [SLICE-1:0] s_seg;
    logic             cout;
    logic             c_msb;

    logic             v_q;
    logic             carry_q;
    logic [PW-1:0]    ps_q;

    if (k == 0) begin : g_first
      assign a_in  = a;
      assign b_in  = b_eff;
      assign cin_k = cin0;
      assign v_in  = in_valid;
      assign ps_d  = s_seg;
    end else begin : g_next
      assign a_in  = g_stage[k-1].g_mid.ar_q;
      assign b_in  = g_stage[k-1].g_mid.br_q;
      assign cin_k = g_stage[k-1].carry_q;
      assign v_in  = g_stage[k-1].v_q;
      assign ps_d  = {s_seg, g_stage[k-1].ps_q};
    end

    carry_chain_segment #(.SLICE(SLICE)) u_seg (
      .a_seg    (a_in[SLICE-1:0]),
      .b_seg    (b_in[SLICE-1:0]),
      .cin      (cin_k),
      .s_seg    (s_seg),
      .cout     (cout),
      .c_msb_in (c_msb)
    );

    always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
        v_q     <= 1'b0;
        carry_q <= 1'b0;
        ps_q    <= '0;
      end else if (adv) begin
        v_q     <= v_in;
        carry_q <= cout;
        ps_q    <= ps_d;
      end
    end

    if (k < STAGES - 1) begin : g_mid
      logic [RW-SLICE-1:0] ar_q;
      logic [RW-SLICE-1:0] br_q;
      logic                unused_c_msb;

      assign unused_c_msb = c_msb;

      always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
          ar_q <= '0;
          br_q <= '0;
        end else if (adv) begin
          ar_q <= a_in[RW-1:SLICE];
          br_q <= b_in[RW-1:SLICE];
        end
      end
    end else begin : g_last
      // Carry into bit WIDTH-1, kept so ov can be formed from registered nodes.
      logic c_msb_q;

      always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
          c_msb_q <= 1'b0;
        end else if (adv) begin
          c_msb_q <= c_msb;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].ps_q;
  assign co        = g_stage[STAGES-1].carry_q;
  assign ov        = g_stage[STAGES-1].carry_q ^ g_stage[STAGES-1].g_last.c_msb_q;

endmodule

// File: tb/tb_carry_chain_pipe_adder.sv
// tb/tb_carry_chain_pipe_adder.sv - directed vector bench for carry_chain_pipe_adder (WIDTH=16, SLICE=4)
module tb_carry_chain_pipe_adder;

  logic        C;
  logic        CLR;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        co;
  logic        ov;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl[NV];

  carry_chain_pipe_adder #(.WIDTH(16), .SLICE(4)) dut (
    .C         (C),
    .CLR       (CLR),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ov        (ov)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int i, input logic v);
    in_valid = v;
    a        = tbl[i].a;
    b        = tbl[i].b;
    ci       = tbl[i].ci;
    sub      = tbl[i].sub;
  endtask

  task automatic chk_beat(input string tag, input int i);
    chk($sformatf("%s_sum[%0d]", tag, i), {16'h0, sum}, {16'h0, tbl[i].s});
    chk($sformatf("%s_co[%0d]", tag, i), {31'h0, co}, {31'h0, tbl[i].co});
    chk($sformatf("%s_ov[%0d]", tag, i), {31'h0, ov}, {31'h0, tbl[i].ov});
  endtask

  initial begin
    int q[$];
    int next_in;
    int got;
    int stall_start;
    logic ov_s;
    logic orv;
    logic exp_rdy;

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0};
    tbl[5] = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
    tbl[6] = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[8] = '{16'h0010, 16'h0010, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[9] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

    // Reset state
    CLR = 1'b1;
    out_ready = 1'b0;
    drive(0, 1'b0);
    repeat (2) @(negedge C);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_sum", {16'h0, sum}, 32'h0);
    chk("rst_co", {31'h0, co}, 32'h0);
    chk("rst_ov", {31'h0, ov}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    CLR = 1'b0;
    out_ready = 1'b1;
    @(negedge C);

    // Back-to-back stream of the whole table with out_ready held high
    for (int t = 0; t < NV + 6; t++) begin
      chk($sformatf("str_in_ready[%0d]", t), {31'h0, in_ready}, 32'h1);
      if (t >= 4 && t < NV + 4) begin
        chk($sformatf("str_valid[%0d]", t), {31'h0, out_valid}, 32'h1);
        chk_beat("str", t - 4);
      end else begin
        chk($sformatf("str_valid[%0d]", t), {31'h0, out_valid}, 32'h0);
      end
      if (t < NV) drive(t, 1'b1);
      else        drive(0, 1'b0);
      @(negedge C);
    end

    // Backpressure: out_ready low for 3 cycles as soon as the first result shows
    next_in = 0;
    got = 0;
    stall_start = 1000;
    for (int n = 0; n < 60 && got < 6; n++) begin
      ov_s = out_valid;
      if (ov_s && stall_start == 1000) stall_start = n;
      if (ov_s) begin
        if (q.size() == 0) chk($sformatf("bp_spurious[%0d]", n), 32'h1, 32'h0);
        else               chk_beat("bp", q[0]);
      end
      orv = !(n >= stall_start && n < stall_start + 3);
      out_ready = orv;
      if (next_in < 6) drive(next_in, 1'b1);
      else             drive(0, 1'b0);
      #1;
      exp_rdy = !ov_s || orv;
      chk($sformatf("bp_in_ready[%0d]", n), {31'h0, in_ready}, {31'h0, exp_rdy});
      if (ov_s && orv && q.size() > 0) begin
        void'(q.pop_front());
        got++;
      end
      if (in_valid && exp_rdy) begin
        q.push_back(next_in);
        next_in++;
      end
      @(negedge C);
    end
    chk("bp_beats_out", got, 6);
    chk("bp_stalled", {31'h0, (stall_start != 1000)}, 32'h1);
    out_ready = 1'b1;
    drive(0, 1'b0);
    repeat (5) @(negedge C);
    chk("bp_drained", {31'h0, out_valid}, 32'h0);

    // Clear with three beats in flight, then one fresh beat
    for (int i = 0; i < 3; i++) begin
      drive(i + 2, 1'b1);
      @(negedge C);
    end
    drive(0, 1'b0);
    CLR = 1'b1;
    #1;
    chk("clr_out_valid_now", {31'h0, out_valid}, 32'h0);
    chk("clr_sum_now", {16'h0, sum}, 32'h0);
    @(negedge C);
    CLR = 1'b0;
    drive(5, 1'b1);
    @(negedge C);
    drive(0, 1'b0);
    for (int t = 1; t <= 4; t++) begin
      if (t < 4) begin
        chk($sformatf("clr_no_stale[%0d]", t), {31'h0, out_valid}, 32'h0);
        @(negedge C);
      end else begin
        chk("clr_new_valid", {31'h0, out_valid}, 32'h1);
        chk("clr_new_sum", {16'h0, sum}, 32'h0003);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
